// File: rtl/transpose_buffer_pingpong_pkg.sv
// ============================================================================
// Module   : tpb_pkg
// Brief    : Shared types and helpers for the ping-pong transpose buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tpb_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } bank_state_e;

  localparam int NUM_BANKS = 2;

  // LSB position of lane 'lane' in a packed bus of 'width'-bit elements.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/transpose_buffer_pingpong_if.sv
// ============================================================================
// Module   : transpose_buffer_pingpong_if
// Brief    : Row-in / column-out stream bundle for the transpose buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface transpose_buffer_pingpong_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int SYSTOLIC_WIDTH = 4
);
  localparam int BUS_W = DATA_WIDTH * SYSTOLIC_WIDTH;

  logic             in_valid;
  logic             in_ready;
  logic [BUS_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [BUS_W-1:0] out_data;
  logic             out_last;
  logic [15:0]      tile_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, tile_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, tile_cnt
  );
endinterface

`default_nettype wire

// File: rtl/transpose_buffer_pingpong_bank.sv
// ============================================================================
// Module   : tpb_bank
// Brief    : One NxN element register array; row write, column/row read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tpb_bank
  import tpb_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int SYSTOLIC_WIDTH = 4,
  parameter int CNT_W          = $clog2(SYSTOLIC_WIDTH)
) (
  input  wire logic                               clk,
  input  wire logic                               rst_n,
  input  wire logic                               we,
  input  wire logic [CNT_W-1:0]                   wr_row,
  input  wire logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] wr_data,
  input  wire logic [CNT_W-1:0]                   rd_col,
`ifdef TPB_BYPASS_EN
  input  wire logic [CNT_W-1:0]                   rd_row,
  output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0]    row_data,
`endif
  output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0]    col_data
);

  logic [DATA_WIDTH-1:0] mem_q [SYSTOLIC_WIDTH][SYSTOLIC_WIDTH];
  logic [DATA_WIDTH-1:0] mem_d [SYSTOLIC_WIDTH][SYSTOLIC_WIDTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int j = 0; j < SYSTOLIC_WIDTH; j++) begin
        mem_d[wr_row][j] = wr_data[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < SYSTOLIC_WIDTH; r++) begin
        for (int c = 0; c < SYSTOLIC_WIDTH; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Column read: lane r carries element [r][rd_col].
  always_comb begin
    col_data = '0;
    for (int r = 0; r < SYSTOLIC_WIDTH; r++) begin
      col_data[lane_lsb(r, DATA_WIDTH) +: DATA_WIDTH] = mem_q[r][rd_col];
    end
  end

`ifdef TPB_BYPASS_EN
  always_comb begin
    row_data = '0;
    for (int j = 0; j < SYSTOLIC_WIDTH; j++) begin
      row_data[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH] = mem_q[rd_row][j];
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/transpose_buffer_pingpong.sv
// ============================================================================
// Module   : transpose_buffer_pingpong
// Brief    : Double-buffered NxN streaming transposer (rows in, columns out).
//            Optional per-tile pass-through mode under macro TPB_BYPASS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module transpose_buffer_pingpong
  import tpb_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int SYSTOLIC_WIDTH = 4,
  parameter int CNT_W          = $clog2(SYSTOLIC_WIDTH)
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
`ifdef TPB_BYPASS_EN
  input  wire logic                  cfg_bypass,
`endif
  transpose_buffer_pingpong_if.slave bus
);

  localparam int               BUS_W    = SYSTOLIC_WIDTH * DATA_WIDTH;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SYSTOLIC_WIDTH - 1);

  bank_state_e      state_q [NUM_BANKS];
  bank_state_e      state_d [NUM_BANKS];
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0] wr_row_q, wr_row_d;
  logic [CNT_W-1:0] rd_col_q, rd_col_d;
  logic [15:0]      tile_cnt_q, tile_cnt_d;
`ifdef TPB_BYPASS_EN
  logic             bypass_q [NUM_BANKS];
  logic             bypass_d [NUM_BANKS];
  logic [BUS_W-1:0] row_data [NUM_BANKS];
`endif

  logic             wr_ready;
  logic             rd_valid;
  logic             wr_fire;
  logic             rd_fire;
  logic [BUS_W-1:0] col_data [NUM_BANKS];

  // Handshake qualifiers decode registered state only.
  always_comb begin
    wr_ready = (state_q[wr_bank_q] == EMPTY) || (state_q[wr_bank_q] == FILL);
    rd_valid = (state_q[rd_bank_q] == FULL)  || (state_q[rd_bank_q] == DRAIN);
    wr_fire  = bus.in_valid && wr_ready;
    rd_fire  = rd_valid && bus.out_ready;
  end

  // Write and read can only touch different banks, since the write bank is
  // EMPTY/FILL while the read bank is FULL/DRAIN.
  always_comb begin
    state_d    = state_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_row_d   = wr_row_q;
    rd_col_d   = rd_col_q;
    tile_cnt_d = tile_cnt_q;
`ifdef TPB_BYPASS_EN
    bypass_d   = bypass_q;
`endif

    if (wr_fire) begin
      if (state_q[wr_bank_q] == EMPTY) begin
        state_d[wr_bank_q] = FILL;
`ifdef TPB_BYPASS_EN
        bypass_d[wr_bank_q] = cfg_bypass;
`endif
      end
      if (wr_row_q == LAST_IDX) begin
        state_d[wr_bank_q] = FULL;
        wr_row_d           = '0;
        wr_bank_d          = ~wr_bank_q;
      end else begin
        wr_row_d = wr_row_q + CNT_W'(1);
      end
    end

    if (rd_fire) begin
      if (state_q[rd_bank_q] == FULL) begin
        state_d[rd_bank_q] = DRAIN;
      end
      if (rd_col_q == LAST_IDX) begin
        state_d[rd_bank_q] = EMPTY;
        rd_col_d           = '0;
        rd_bank_d          = ~rd_bank_q;
        tile_cnt_d         = tile_cnt_q + 16'd1;
      end else begin
        rd_col_d = rd_col_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        state_q[b] <= EMPTY;
`ifdef TPB_BYPASS_EN
        bypass_q[b] <= 1'b0;
`endif
      end
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_row_q   <= '0;
      rd_col_q   <= '0;
      tile_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_row_q   <= wr_row_d;
      rd_col_q   <= rd_col_d;
      tile_cnt_q <= tile_cnt_d;
`ifdef TPB_BYPASS_EN
      bypass_q   <= bypass_d;
`endif
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    tpb_bank #(
      .DATA_WIDTH     (DATA_WIDTH),
      .SYSTOLIC_WIDTH (SYSTOLIC_WIDTH),
      .CNT_W          (CNT_W)
    ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (wr_fire && (wr_bank_q == 1'(b))),
      .wr_row   (wr_row_q),
      .wr_data  (bus.in_data),
      .rd_col   (rd_col_q),
`ifdef TPB_BYPASS_EN
      .rd_row   (rd_col_q),
      .row_data (row_data[b]),
`endif
      .col_data (col_data[b])
    );
  end

  always_comb begin
    bus.out_data = col_data[rd_bank_q];
`ifdef TPB_BYPASS_EN
    if (bypass_q[rd_bank_q]) begin
      bus.out_data = row_data[rd_bank_q];
    end
`endif
    bus.in_ready  = wr_ready;
    bus.out_valid = rd_valid;
    bus.out_last  = rd_valid && (rd_col_q == LAST_IDX);
    bus.tile_cnt  = tile_cnt_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_transpose_buffer_pingpong.sv
// ============================================================================
// Module   : tb_transpose_buffer_pingpong
// Brief    : Self-checking bench: directed table, streaming, backpressure,
//            reset and random traffic against a queue-based transpose model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_transpose_buffer_pingpong;
  localparam int DW = 16;
  localparam int N  = 4;
  localparam int W  = DW * N;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  transpose_buffer_pingpong_if #(.DATA_WIDTH(DW), .SYSTOLIC_WIDTH(N)) bus ();

`ifdef TPB_BYPASS_EN
  logic cfg_bypass = 1'b0;
`endif

  transpose_buffer_pingpong #(
    .DATA_WIDTH     (DW),
    .SYSTOLIC_WIDTH (N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef TPB_BYPASS_EN
    .cfg_bypass (cfg_bypass),
`endif
    .bus        (bus)
  );

  typedef struct { logic [W-1:0] data; bit last; } exp_t;
  typedef struct { logic [W-1:0] row; logic [W-1:0] col; bit last; } vec_t;

  int           checks   = 0;
  int           failures = 0;
  exp_t         exp_q[$];
  logic [W-1:0] part_rows [N];
  int           part_cnt = 0;
  bit           part_byp = 0;
  int           drained  = 0;
  bit           stall_pending = 0;
  logic [W-1:0] stall_data;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rnd_row();
    return {$urandom, $urandom};
  endfunction

  // Reference: buffer rows of a tile; once complete, queue its N outputs.
  task automatic model_write(input logic [W-1:0] row, input bit byp);
    if (part_cnt == 0) part_byp = byp;
    part_rows[part_cnt] = row;
    part_cnt++;
    if (part_cnt == N) begin
      for (int c = 0; c < N; c++) begin
        exp_t e;
        if (part_byp) e.data = part_rows[c];
        else for (int r = 0; r < N; r++) e.data[r*DW +: DW] = part_rows[r][c*DW +: DW];
        e.last = (c == N - 1);
        exp_q.push_back(e);
      end
      part_cnt = 0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    part_cnt      = 0;
    drained       = 0;
    stall_pending = 0;
  endtask

  // One clock cycle: drive, sample at negedge, check, update model after edge.
  task automatic step(input bit iv, input logic [W-1:0] id, input bit ordy,
                      input bit byp, output bit accepted);
    bit exp_rdy, exp_vld, rd;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
`ifdef TPB_BYPASS_EN
    cfg_bypass = byp;
`endif
    @(negedge clk);
    exp_rdy = ((exp_q.size() + N - 1) / N) < 2;
    exp_vld = exp_q.size() > 0;
    chk("in_ready", W'(bus.in_ready), W'(exp_rdy));
    chk("out_valid", W'(bus.out_valid), W'(exp_vld));
    if (exp_vld) begin
      chk("out_data", bus.out_data, exp_q[0].data);
      chk("out_last", W'(bus.out_last), W'(exp_q[0].last));
    end else begin
      chk("out_last_idle", W'(bus.out_last), W'(0));
    end
    chk("tile_cnt", W'(bus.tile_cnt), W'(16'(drained)));
    if (stall_pending && bus.out_valid) chk("hold_data", bus.out_data, stall_data);
    stall_pending = bus.out_valid && !ordy;
    stall_data    = bus.out_data;
    accepted = iv && exp_rdy;
    rd       = exp_vld && ordy;
    @(posedge clk);
    #1;
    if (rd) begin
      if (exp_q[0].last) drained++;
      void'(exp_q.pop_front());
    end
    if (accepted) model_write(id, byp);
  endtask

  task automatic drain();
    bit acc;
    int guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      step(1'b0, '0, 1'b1, 1'b0, acc);
      guard++;
    end
    if (guard >= 200) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0 columns left", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [N];
    bit   acc;
    logic [W-1:0] r9;

    tbl[0] = '{row: 64'h0003_0002_0001_0000, col: 64'h0030_0020_0010_0000, last: 1'b0};
    tbl[1] = '{row: 64'h0013_0012_0011_0010, col: 64'h0031_0021_0011_0001, last: 1'b0};
    tbl[2] = '{row: 64'h0023_0022_0021_0020, col: 64'h0032_0022_0012_0002, last: 1'b0};
    tbl[3] = '{row: 64'h0033_0032_0031_0030, col: 64'h0033_0023_0013_0003, last: 1'b1};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset values while held in reset.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", W'(bus.in_ready), W'(1));
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_out_last", W'(bus.out_last), W'(0));
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_tile_cnt", W'(bus.tile_cnt), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed tile from the table; columns from the cycle after row 3.
    for (int i = 0; i < N; i++) step(1'b1, tbl[i].row, 1'b1, 1'b0, acc);
    for (int c = 0; c < N; c++) begin
      chk("tbl_valid", W'(bus.out_valid), W'(1));
      chk("tbl_col", bus.out_data, tbl[c].col);
      chk("tbl_last", W'(bus.out_last), W'(tbl[c].last));
      step(1'b0, '0, 1'b1, 1'b0, acc);
    end
    chk("tbl_tile_cnt", W'(bus.tile_cnt), W'(1));

    // Back-to-back streaming of 3 tiles.
    for (int i = 0; i < 3 * N; i++) step(1'b1, rnd_row(), 1'b1, 1'b0, acc);
    drain();
    chk("b2b_tile_cnt", W'(bus.tile_cnt), W'(4));

    // Backpressure: two full tiles, a stalled ninth row, then release.
    for (int i = 0; i < 2 * N; i++) step(1'b1, rnd_row(), 1'b0, 1'b0, acc);
    chk("bp_in_ready_low", W'(bus.in_ready), W'(0));
    r9 = rnd_row();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, r9, 1'b0, 1'b0, acc);
      chk("bp_row_stalled", W'(acc), W'(0));
    end
    for (int i = 0; i < N; i++) begin
      step(1'b1, r9, 1'b1, 1'b0, acc);
      chk("bp_row_held", W'(acc), W'(0));
    end
    step(1'b1, r9, 1'b1, 1'b0, acc);
    chk("bp_row_taken", W'(acc), W'(1));
    for (int i = 0; i < N - 1; i++) step(1'b1, rnd_row(), 1'b1, 1'b0, acc);
    drain();

    // Random traffic: 20 tiles with random valid/ready.
    begin
      int sent = 0;
      int cyc  = 0;
      while (sent < 20 * N && cyc < 3000) begin
        step(($urandom % 4) != 0, rnd_row(), $urandom % 2, 1'b0, acc);
        if (acc) sent++;
        cyc++;
      end
      if (sent < 20 * N) begin
        failures++;
        $display("FAIL random_timeout actual=%0d required=%0d rows", sent, 20 * N);
      end
      drain();
    end

    // Reset mid-tile with a full tile also pending.
    for (int i = 0; i < N + 2; i++) step(1'b1, rnd_row(), 1'b0, 1'b0, acc);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", W'(bus.in_ready), W'(1));
    chk("mid_rst_out_valid", W'(bus.out_valid), W'(0));
    chk("mid_rst_tile_cnt", W'(bus.tile_cnt), W'(0));
    chk("mid_rst_out_data", bus.out_data, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) step(1'b1, rnd_row(), 1'b1, 1'b0, acc);
    drain();
    chk("post_rst_tile_cnt", W'(bus.tile_cnt), W'(1));

`ifdef TPB_BYPASS_EN
    // Tile A passes through, tile B transposes; mode latched on first row.
    for (int i = 0; i < N; i++) step(1'b1, rnd_row(), 1'b0, (i == 0) ? 1'b1 : 1'b0, acc);
    for (int i = 0; i < N; i++) step(1'b1, rnd_row(), 1'b0, (i == 0) ? 1'b0 : 1'b1, acc);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/transpose_buffer_pingpong.md
Name: transpose_buffer_pingpong

Overview:
- Streaming, double-buffered N×N matrix transposer. It is the parametrised successor of the single-bank shift-register transposer that feeds the systolic array.
- Accepts one matrix row per input handshake and emits one matrix column per output handshake.
- Two banks: one tile can be written while the previous tile is read out.
- Sits between the operand loader and the systolic-array column feeders. The array width is fully generic.

Parameters:
- DATA_WIDTH, 16, bits per matrix element.
- SYSTOLIC_WIDTH, 4, matrix dimension N (rows = columns = lanes). Legal range ≥2.
- CNT_W, $clog2(SYSTOLIC_WIDTH), width of the row and column counters. Derived; do not override.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data holds a valid row.
- in_ready  out  1  block can accept a row this cycle.
- in_data  in  SYSTOLIC_WIDTH*DATA_WIDTH  row r; element j occupies [(j+1)*DATA_WIDTH-1 : j*DATA_WIDTH].
- out_valid  out  1  out_data holds a valid column.
- out_ready  in  1  downstream accepts the column.
- out_data  out  SYSTOLIC_WIDTH*DATA_WIDTH  column c; lane r = element A[r][c].
- out_last  out  1  high with the final column (c = N-1) of a tile.
- tile_cnt  out  16  wrapping count of fully drained tiles.

Behaviour:
- Reset (async assert, sync release) clears:
  - both bank states to EMPTY;
  - wr_bank, rd_bank and all counters to 0;
  - bank storage to 0.
- Reset values of outputs: in_ready=1, out_valid=0, out_last=0, out_data=0, tile_cnt=0.
- Per-bank state machine:
  - EMPTY → FILL on the first accepted row.
  - FILL → FULL on the accepted row with wr_row=N-1.
  - FULL → DRAIN on the first accepted column; with N=1 this is not used (N≥2 enforced).
  - DRAIN → EMPTY on the accepted column with rd_col=N-1.
- Write side:
  - in_ready = (state[wr_bank] is EMPTY or FILL). It is a registered state decode with no combinational path from in_valid.
  - Write handshake (in_valid & in_ready): store the row into bank[wr_bank] row wr_row, then wr_row++.
  - At wr_row=N-1: wr_row wraps to 0, the bank goes FULL, wr_bank toggles.
- Read side:
  - out_valid = (state[rd_bank] is FULL or DRAIN).
  - out_data is driven combinationally from bank[rd_bank] column rd_col.
  - out_last = out_valid & (rd_col=N-1).
  - Read handshake (out_valid & out_ready): rd_col++.
  - At rd_col=N-1: rd_col wraps to 0, the bank goes EMPTY, rd_bank toggles, tile_cnt++ (wraps at 2^16).
- Latency: last row of a tile accepted at edge t → out_valid=1 in the cycle after t. Minimum tile-to-tile gap is 0 when both sides stream.
- Backpressure:
  - out_ready=0 holds out_data and out_last stable, and rd_col is unchanged.
  - Both banks FULL/DRAIN → in_ready=0 until a bank is freed.
- Simultaneous events:
  - Write and read handshakes in the same cycle on different banks are both honoured.
  - A bank freed by its last-column read handshake at edge t is writable from cycle t+1. There is no same-cycle reuse, so no write/read race on one bank.
- in_valid=0 with in_ready=1 leaves state unchanged. A partially filled bank stays in FILL indefinitely.
- Reset mid-tile discards all stored data and returns to the reset state. No outputs glitch high during reset.

Optional Feature:
- Macro TPB_BYPASS_EN.
- When defined:
  - Adds input port cfg_bypass (1 bit), sampled per tile on the first write of that tile and stored per bank.
  - For a bank whose bypass flag is 1, the read side emits rows unchanged in original order: out_data = bank row rd_col.
  - Handshake, latency, out_last and tile_cnt are identical to the transpose mode.
- When undefined: no cfg_bypass port, no per-bank flag, and the block always transposes.

Decomposition:
- Package tpb_pkg holds:
  - typedef bank_state_e {EMPTY, FILL, FULL, DRAIN} (2-bit enum);
  - localparam NUM_BANKS=2;
  - a helper function for lane slicing.
- One natural sub-module: tpb_bank, a single N×N register array.
  - Inputs: row write port (we, row index, row data).
  - Outputs: column read (col index → column data) and row read (for bypass).
  - Instantiate twice.

Test Plan:
- N=4, DW=16, out_ready=1; write rows {0x0003,0x0002,0x0001,0x0000}, {0x0013..0x0010}, {0x0023..0x0020}, {0x0033..0x0030} → columns appear from the cycle after the 4th row. Column 0 lanes = 0x0000,0x0010,0x0020,0x0030; out_last only on column 3; tile_cnt=1.
- Back-to-back: stream 3 tiles with in_valid and out_ready held at 1 → in_ready never drops, and 12 columns are output contiguously with no bubbles after the first latency.
- Backpressure: out_ready=0 after tile 1 is full, write tile 2 → after 4 more rows in_ready=0 and 5th row is stalled. Raise out_ready → tile 1 columns are correct and in_ready reasserts the cycle after tile 1's last column.
- Random out_ready toggling over 20 tiles of random data → every column matches the reference transpose, and out_data stays stable while out_valid & !out_ready.
- Reset asserted after 2 rows written → in_ready=1, out_valid=0, tile_cnt=0 immediately. The next 4 rows form a clean tile with no residue from the old rows.
- TPB_BYPASS_EN: tile A with cfg_bypass=1, tile B with cfg_bypass=0 → A is emitted as original rows, B as columns, and per-tile mode is honoured across the bank toggle.
